// File: rtl/cc_addr_decoder.sv
// cc_addr_decoder: accepts AR read requests, buffers them in a 2-entry skid buffer
// (OUT + SKID) and presents the OUT address split into tag/index/offset/bank fields.
// Acceptance is gated when any downstream FIFO reports almost-full.
//
// Optional feature macro: CC_DEC_STATS_EN enables saturating request/stall counters.
// Without it, req_cnt_o and stall_cnt_o are tied to 0.
//
// Ports:
//   clk, rst          - clock (rising edge), synchronous active-high reset
//   inct_araddr_i     - request address
//   inct_arvalid_i    - request valid
//   inct_arready_o    - request ready (no skid occupant and no almost-full)
//   fifo_afull_i      - downstream almost-full flags
//   dec_valid_o       - decoded request valid
//   dec_ready_i       - downstream ready
//   tag_o, index_o,
//   offset_o, bank_o  - fields of the OUT address
//   hs_pulse_o        - high in the cycle an AR handshake occurs
//   req_cnt_o         - accepted-request count
//   stall_cnt_o       - cycles with arvalid high but arready low
module cc_addr_decoder #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned OFFSET_W  = 6,
  parameter int unsigned INDEX_W   = 8,
  parameter int unsigned NUM_BANKS = 1,
  parameter int unsigned NUM_FIFO  = 4,
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   inct_araddr_i,
  input  logic                inct_arvalid_i,
  output logic                inct_arready_o,
  input  logic [NUM_FIFO-1:0] fifo_afull_i,
  output logic                dec_valid_o,
  input  logic                dec_ready_i,
  output logic [TAG_W-1:0]    tag_o,
  output logic [INDEX_W-1:0]  index_o,
  output logic [OFFSET_W-1:0] offset_o,
  output logic [BANK_W-1:0]   bank_o,
  output logic                hs_pulse_o,
  output logic [31:0]         req_cnt_o,
  output logic [31:0]         stall_cnt_o
);

  // Occupancy of the OUT/SKID pair; OUT valid in StOne/StFull, SKID valid only in StFull.
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] skid_addr_q;
  logic              acc;
  logic              pop;

  assign inct_arready_o = (state_q != StFull) && !(|fifo_afull_i);
  assign acc            = inct_arvalid_i && inct_arready_o;
  assign hs_pulse_o     = acc;
  assign dec_valid_o    = (state_q != StEmpty);
  assign pop            = dec_valid_o && dec_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      out_addr_q  <= '0;
      skid_addr_q <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_q    <= StOne;
            out_addr_q <= inct_araddr_i;
          end
        end
        StOne: begin
          if (acc && pop) begin
            out_addr_q <= inct_araddr_i;
          end else if (acc) begin
            // Downstream stalled: park the new request behind OUT.
            state_q     <= StFull;
            skid_addr_q <= inct_araddr_i;
          end else if (pop) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            state_q    <= StOne;
            out_addr_q <= skid_addr_q;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign tag_o    = out_addr_q[ADDR_W-1 -: TAG_W];
  assign index_o  = out_addr_q[OFFSET_W +: INDEX_W];
  assign offset_o = out_addr_q[OFFSET_W-1:0];

  generate
    if (NUM_BANKS == 1) begin : g_single_bank
      assign bank_o = '0;
    end else begin : g_multi_bank
      // Bank is the low bits of the set index.
      assign bank_o = out_addr_q[OFFSET_W +: BANK_W];
    end
  endgenerate

`ifdef CC_DEC_STATS_EN
  logic [31:0] req_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (acc && (req_cnt_q != 32'hFFFF_FFFF)) begin
        req_cnt_q <= req_cnt_q + 32'd1;
      end
      if (inct_arvalid_i && !inct_arready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign req_cnt_o   = req_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign req_cnt_o   = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cc_addr_decoder.sv
// Self-checking bench for cc_addr_decoder. A queue-based reference model holds the
// requests the decoder should be buffering; fields are computed from the front address
// with plain shifts and masks. A second instance with NUM_BANKS=4 checks bank selection.
module tb_cc_addr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic [3:0]  afull;
  logic        dec_ready;

  logic        arready, hs, dec_valid;
  logic [17:0] tag;
  logic [7:0]  index;
  logic [5:0]  offset;
  logic [0:0]  bank;
  logic [31:0] req_cnt, stall_cnt;

  logic        arready4, hs4, dec_valid4;
  logic [17:0] tag4;
  logic [7:0]  index4;
  logic [5:0]  offset4;
  logic [1:0]  bank4;
  logic [31:0] req_cnt4, stall_cnt4;

  always #5 clk = ~clk;

  cc_addr_decoder u_dut (
    .clk            (clk),
    .rst            (rst),
    .inct_araddr_i  (araddr),
    .inct_arvalid_i (arvalid),
    .inct_arready_o (arready),
    .fifo_afull_i   (afull),
    .dec_valid_o    (dec_valid),
    .dec_ready_i    (dec_ready),
    .tag_o          (tag),
    .index_o        (index),
    .offset_o       (offset),
    .bank_o         (bank),
    .hs_pulse_o     (hs),
    .req_cnt_o      (req_cnt),
    .stall_cnt_o    (stall_cnt)
  );

  cc_addr_decoder #(
    .NUM_BANKS (4)
  ) u_dut4 (
    .clk            (clk),
    .rst            (rst),
    .inct_araddr_i  (araddr),
    .inct_arvalid_i (arvalid),
    .inct_arready_o (arready4),
    .fifo_afull_i   (afull),
    .dec_valid_o    (dec_valid4),
    .dec_ready_i    (dec_ready),
    .tag_o          (tag4),
    .index_o        (index4),
    .offset_o       (offset4),
    .bank_o         (bank4),
    .hs_pulse_o     (hs4),
    .req_cnt_o      (req_cnt4),
    .stall_cnt_o    (stall_cnt4)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model state.
  logic [31:0] q[$];
  logic [31:0] shown;
  logic [31:0] req_exp;
  logic [31:0] stall_exp;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Entered at posedge+1: drive inputs, check mid-cycle, advance model on the edge.
  task automatic cycle(input logic r, input logic [31:0] a, input logic v,
                       input logic [3:0] f, input logic rd);
    logic exp_rdy, exp_acc, exp_pop;
    rst = r; araddr = a; arvalid = v; afull = f; dec_ready = rd;
    #4;
    exp_rdy = (q.size() < 2) && (f == 4'd0);
    exp_acc = v && exp_rdy;
    exp_pop = (q.size() > 0) && rd;
    chk("arready",   {31'd0, arready},   {31'd0, exp_rdy});
    chk("hs_pulse",  {31'd0, hs},        {31'd0, exp_acc});
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, q.size() > 0});
    chk("tag",       {14'd0, tag},       shown >> 14);
    chk("index",     {24'd0, index},     (shown >> 6) & 32'hFF);
    chk("offset",    {26'd0, offset},    shown & 32'h3F);
    chk("bank1",     {31'd0, bank},      32'd0);
    chk("bank4",     {30'd0, bank4},     (shown >> 6) & 32'h3);
    chk("dec_valid4", {31'd0, dec_valid4}, {31'd0, q.size() > 0});
    chk("req_cnt",   req_cnt,            req_exp);
    chk("stall_cnt", stall_cnt,          stall_exp);
    @(posedge clk);
    if (r) begin
      q.delete();
      shown     = 32'd0;
      req_exp   = 32'd0;
      stall_exp = 32'd0;
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_acc) q.push_back(a);
      if (q.size() > 0) shown = q[0];
`ifdef CC_DEC_STATS_EN
      if (exp_acc) req_exp++;
      if (v && !exp_rdy) stall_exp++;
`endif
    end
    #1;
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; araddr = 32'd0; arvalid = 1'b0; afull = 4'd0; dec_ready = 1'b0;
    q.delete(); shown = 32'd0; req_exp = 32'd0; stall_exp = 32'd0;
    @(posedge clk);
    #1;
    // Reset state, including arready following afull combinationally.
    cycle(1'b1, 32'd0, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 4'b0001, 1'b1);

    // Single known request.
    cycle(1'b0, 32'hABCD_1234, 1'b1, 4'd0, 1'b1);
    chk("tp1_tag",    {14'd0, tag},    32'h0002_AF34);
    chk("tp1_index",  {24'd0, index},  32'h0000_0048);
    chk("tp1_offset", {26'd0, offset}, 32'h0000_0034);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);

    // Back-to-back stream at full rate.
    for (int i = 0; i < 8; i++) cycle(1'b0, $urandom, 1'b1, 4'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);

    // Downstream stall while streaming, then drain.
    for (int i = 0; i < 4; i++) cycle(1'b0, $urandom, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);

    // Almost-full on one FIFO blocks acceptance.
    for (int i = 0; i < 5; i++) cycle(1'b0, $urandom, 1'b1, 4'b0100, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);

    // Bank selection: index 8'h47 -> bank 2'b11 on the 4-bank instance.
    cycle(1'b0, 32'h0000_11C0, 1'b1, 4'd0, 1'b1);
    chk("tp_bank4", {30'd0, bank4}, 32'd3);
    chk("tp_bank1", {31'd0, bank},  32'd0);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      cycle(1'b0, a, 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0,
            1'($urandom_range(0, 2) != 0));
    end

    // Fill both registers, then reset while FULL: buffered requests are discarded.
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);
    cycle(1'b0, 32'h1111_1111, 1'b1, 4'd0, 1'b0);
    cycle(1'b0, 32'h2222_2222, 1'b1, 4'd0, 1'b0);
    chk("full_arready", {31'd0, arready}, 32'd0);
    cycle(1'b1, 32'h3333_3333, 1'b1, 4'd0, 1'b0);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_req_cnt", req_cnt, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cc_addr_decoder.md
# cc_addr_decoder

Parametrised, buffered successor to the cache controller's request decoder. It accepts read requests from the interconnect AR channel and splits each address into tag, index, offset and bank fields. A 2-entry skid buffer decouples the decoded output from the downstream tag-lookup stage. New requests are gated whenever any of NUM_FIFO downstream FIFOs reports almost-full.

## Interface
Parameters:
- ADDR_W, 32, request address width
- OFFSET_W, 6, byte-offset field width (line size 2^OFFSET_W bytes)
- INDEX_W, 8, set-index field width
- NUM_BANKS, 1, tag/data banks; power of two, 1..2^INDEX_W
- NUM_FIFO, 4, number of almost-full inputs gating acceptance
- Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W (must be ≥1); BANK_W = max(1, clog2(NUM_BANKS))

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- inct_araddr_i  in  ADDR_W  request address
- inct_arvalid_i  in  1  request valid
- inct_arready_o  out  1  request ready
- fifo_afull_i  in  NUM_FIFO  almost-full flags (miss addr, miss req, hit flag, hit data, ...)
- dec_valid_o  out  1  decoded request valid
- dec_ready_i  in  1  downstream ready
- tag_o  out  TAG_W  address[ADDR_W-1 : INDEX_W+OFFSET_W]
- index_o  out  INDEX_W  address[INDEX_W+OFFSET_W-1 : OFFSET_W]
- offset_o  out  OFFSET_W  address[OFFSET_W-1 : 0]
- bank_o  out  BANK_W  index_o[BANK_W-1:0]; constant 0 when NUM_BANKS=1
- hs_pulse_o  out  1  high in the cycle an AR handshake occurs
- req_cnt_o  out  32  accepted-request count (see Configuration)
- stall_cnt_o  out  32  back-pressured-cycle count (see Configuration)

## Operation
- Storage: output register (OUT) plus skid register (SKID), each holding the full address and a valid bit. Fields are decoded combinationally from OUT.
- Occupancy states:
  - EMPTY: neither register valid.
  - ONE: OUT valid.
  - FULL: OUT and SKID valid.
- inct_arready_o = !SKID.valid && !(|fifo_afull_i). This is combinational from registered state and afull; it does not depend on inct_arvalid_i.
- Handshake (acc) = inct_arvalid_i && inct_arready_o. hs_pulse_o = acc. Downstream pop (pop) = dec_valid_o && dec_ready_i.
- Transitions:
  - EMPTY: acc → ONE, with OUT ← addr.
  - ONE:
    - acc && pop → ONE, with OUT ← addr.
    - acc && !pop → FULL, with SKID ← addr.
    - !acc && pop → EMPTY.
    - Otherwise hold.
  - FULL (no acc possible): pop → ONE, with OUT ← SKID.
- Order is strictly FIFO. No request is dropped or duplicated.
- While dec_valid_o && !dec_ready_i, all dec_* outputs are held stable.
- Afull rising while OUT/SKID hold data does not flush them. Only new acceptance stops.
- Reset: all valid bits 0, address registers 0. Consequently dec_valid_o=0, tag_o/index_o/offset_o/bank_o=0, inct_arready_o = !(|fifo_afull_i), hs_pulse_o=0 (absent arvalid), counters 0.
- Reset asserted mid-operation discards buffered requests in that cycle. No handshake is counted in a reset cycle.

## Timing
- Latency: a request accepted at edge N appears on dec_* after edge N (visible in cycle N+1) when OUT was empty or popping.
- Throughput: 1 request/cycle sustained with dec_ready_i=1 and no afull.
- One cycle of downstream stall is absorbed by SKID without deasserting inct_arready_o in the acceptance cycle. inct_arready_o drops in the following cycle.
- Afull → arready deassertion is combinational (same cycle).

## Configuration
- CC_DEC_STATS_EN defined:
  - req_cnt_o increments on every acc.
  - stall_cnt_o increments on every cycle with inct_arvalid_i && !inct_arready_o.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Not defined: counter registers are not instantiated; req_cnt_o and stall_cnt_o are tied to 0.

## Test plan
- Reset, then single request addr 32'hABCD_1234 with dec_ready_i=1 → hs_pulse_o for 1 cycle. Next cycle dec_valid_o=1, tag_o=18'h2AF34, index_o=8'h48, offset_o=6'h34.
- Back-to-back stream of 8 addresses, dec_ready_i=1, no afull → arready constantly 1, outputs in order at 1/cycle, req_cnt_o=8 (with macro).
- dec_ready_i=0 while streaming → two requests accepted, then arready=0. Outputs held stable. Releasing dec_ready_i drains both in order, then arready returns to 1.
- fifo_afull_i[2]=1 for 5 cycles with arvalid high → no handshake, hs_pulse_o=0, stall_cnt_o=5 (with macro; 0 without).
- NUM_BANKS=4, INDEX_W=8, address index 8'h47 → bank_o=2'b11. With NUM_BANKS=1 → bank_o=0.
- rst asserted while FULL → next cycle dec_valid_o=0, arready=1, counters=0. Pre-reset requests never appear.
